// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution read-side controller.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPUTE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_RELOAD  = 3'd4
  } conv_rd_state_t;

  // Number of fully overlapped output positions for one x/f vector pair.
  function automatic int num_out(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Up-counter with enable, synchronous clear and a terminal-count flag at MAX.
module mod_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MAX));

  // Clear wins over enable; enabling at MAX wraps to 0.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ctrl_conv_mem_read.sv
// Read-side sequencer for the convolution datapath: walks x/f read addresses for
// every output, drives MAC enable/clear, hands results out, then reloads the memories.
module ctrl_conv_mem_read
  import conv_pkg::*;
#(
  parameter int X_SIZE       = 8,
  parameter int F_SIZE       = 4,
  parameter int X_ADDR_WIDTH = 3,
  parameter int F_ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    x_loaded,
  input  logic                    f_loaded,
  output logic [X_ADDR_WIDTH-1:0] x_addr,
  output logic [F_ADDR_WIDTH-1:0] f_addr,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    mem_reload,
  output conv_rd_state_t          state_dbg
);

  localparam int NUM_OUT = num_out(X_SIZE, F_SIZE);

  // Handshake: an output transfers on a rising clk edge where m_valid & m_ready
  // are both high. m_valid, once raised, holds until that transfer; m_ready is
  // only looked at while in ST_OUTPUT.

  conv_rd_state_t state, next_state;

  logic [F_ADDR_WIDTH-1:0] j;
  logic [X_ADDR_WIDTH-1:0] out_idx;
  logic j_en, j_clr, j_tc;
  logic out_en, out_clr, out_tc;
  logic handshake;

  mod_counter #(.WIDTH(F_ADDR_WIDTH), .MAX(F_SIZE - 1)) u_j_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (j_en),
    .clr   (j_clr),
    .count (j),
    .tc    (j_tc)
  );

  mod_counter #(.WIDTH(X_ADDR_WIDTH), .MAX(NUM_OUT - 1)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out_en),
    .clr   (out_clr),
    .count (out_idx),
    .tc    (out_tc)
  );

  assign handshake = (state == ST_OUTPUT) && m_valid && m_ready;
  assign f_addr    = j;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    j_en       = 1'b0;
    j_clr      = 1'b0;
    out_en     = 1'b0;
    out_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        j_clr   = 1'b1;
        out_clr = 1'b1;
        if (x_loaded && f_loaded) next_state = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // j parks on its last tap so addresses stay frozen through WAIT/OUTPUT.
        if (j_tc) next_state = ST_WAIT;
        else      j_en       = 1'b1;
      end
      ST_WAIT: next_state = ST_OUTPUT;
      ST_OUTPUT: begin
        if (handshake) begin
          if (out_tc) begin
            next_state = ST_RELOAD;
          end else begin
            out_en     = 1'b1;
            j_clr      = 1'b1;
            next_state = ST_COMPUTE;
          end
        end
      end
      ST_RELOAD: begin
        j_clr      = 1'b1;
        out_clr    = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // x_addr is kept as its own register tracking out_idx + j, so it needs no adder
  // after the counters and has no path from m_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_addr <= '0;
    end else if (j_clr) begin
      x_addr <= out_en ? out_idx + X_ADDR_WIDTH'(1) : '0;
    end else if (j_en) begin
      x_addr <= x_addr + X_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      m_valid    <= 1'b0;
      mem_reload <= 1'b0;
    end else begin
      mac_en     <= (state == ST_COMPUTE);
      mac_clr    <= (state == ST_COMPUTE) && (j == '0);
      m_valid    <= (next_state == ST_OUTPUT);
      mem_reload <= (next_state == ST_RELOAD);
    end
  end

endmodule

// File: tb/tb_ctrl_conv_mem_read.sv
// Directed bench for ctrl_conv_mem_read with modelled memories, MAC and write
// controllers; accumulator results are checked against a reference convolution.
module tb_ctrl_conv_mem_read;
  import conv_pkg::*;

  localparam int X_SIZE  = 8;
  localparam int F_SIZE  = 4;
  localparam int NUM_OUT = 5;

  logic clk = 1'b0;
  logic reset, x_loaded, f_loaded, m_ready;
  logic [2:0] x_addr;
  logic [1:0] f_addr;
  logic mac_en, mac_clr, m_valid, mem_reload;
  conv_rd_state_t state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_outputs = 0;
  int reload_cnt = 0;

  logic [7:0]  x_mem [X_SIZE];
  logic [7:0]  f_mem [F_SIZE];
  logic [7:0]  x_q, f_q;
  logic [31:0] acc;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  ctrl_conv_mem_read #(
    .X_SIZE(8), .F_SIZE(4), .X_ADDR_WIDTH(3), .F_ADDR_WIDTH(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x_loaded   (x_loaded),
    .f_loaded   (f_loaded),
    .x_addr     (x_addr),
    .f_addr     (f_addr),
    .mac_en     (mac_en),
    .mac_clr    (mac_clr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .mem_reload (mem_reload),
    .state_dbg  (state_dbg)
  );

  // Synchronous-read memories and the MAC accumulator.
  always @(posedge clk) begin
    x_q <= x_mem[x_addr];
    f_q <= f_mem[f_addr];
    if (mac_en) acc <= mac_clr ? 32'(x_q) * 32'(f_q) : acc + 32'(x_q) * 32'(f_q);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score a pending handshake, advance, and model the write controllers
  // dropping their loaded flags on the edge that ends a reload pulse.
  task automatic step();
    logic rl;
    if (!reset && m_valid && m_ready) begin
      n_outputs++;
      if (exp_q.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
      else check("y_result", acc, exp_q.pop_front());
    end
    rl = mem_reload;
    @(posedge clk);
    #1;
    if (rl) begin
      x_loaded = 1'b0;
      f_loaded = 1'b0;
      reload_cnt++;
    end
  endtask

  task automatic push_expected();
    logic [31:0] y;
    for (int i = 0; i < NUM_OUT; i++) begin
      y = '0;
      for (int k = 0; k < F_SIZE; k++) y += 32'(x_mem[i + k]) * 32'(f_mem[k]);
      exp_q.push_back(y);
    end
  endtask

  task automatic load_vector();
    for (int i = 0; i < X_SIZE; i++) x_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < F_SIZE; i++) f_mem[i] = 8'($urandom_range(0, 255));
    push_expected();
  endtask

  task automatic start_vector();
    load_vector();
    x_loaded = 1'b1;
    f_loaded = 1'b1;
    step();
    check("start_state", 32'(state_dbg), 32'(ST_COMPUTE));
  endtask

  task automatic check_cycle(input int o, input int c);
    int a;
    a = (c < F_SIZE) ? c : F_SIZE - 1;
    check("x_addr", 32'(x_addr), 32'(o + a));
    check("f_addr", 32'(f_addr), 32'(a));
    check("mac_en", 32'(mac_en), 32'(c >= 1 && c <= F_SIZE));
    check("mac_clr", 32'(mac_clr), 32'(c == 1));
    check("m_valid", 32'(m_valid), 32'(c == F_SIZE + 1));
  endtask

  // Entered at the first COMPUTE cycle of output o; returns at the next one.
  task automatic run_output(input int o, input int stall);
    for (int c = 0; c < F_SIZE + 2; c++) begin
      check_cycle(o, c);
      if (c == F_SIZE + 1) begin
        for (int s = 0; s < stall; s++) begin
          m_ready = 1'b0;
          step();
          check("stall_m_valid", 32'(m_valid), 32'd1);
          check("stall_x_addr", 32'(x_addr), 32'(o + F_SIZE - 1));
          check("stall_f_addr", 32'(f_addr), 32'(F_SIZE - 1));
          check("stall_mac_en", 32'(mac_en), 32'd0);
          check("stall_state", 32'(state_dbg), 32'(ST_OUTPUT));
        end
        m_ready = 1'b1;
      end
      step();
    end
  endtask

  task automatic finish_vector();
    check("reload_pulse", 32'(mem_reload), 32'd1);
    check("reload_state", 32'(state_dbg), 32'(ST_RELOAD));
    check("reload_m_valid", 32'(m_valid), 32'd0);
    step();
    check("reload_end", 32'(mem_reload), 32'd0);
    check("post_reload_state", 32'(state_dbg), 32'(ST_IDLE));
    step();
    check("no_retrigger", 32'(state_dbg), 32'(ST_IDLE));
    check("idle_mac_en", 32'(mac_en), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    x_loaded = 1'b0;
    f_loaded = 1'b0;
    m_ready  = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      x_loaded = 1'($urandom_range(0, 1));
      f_loaded = 1'($urandom_range(0, 1));
      m_ready  = 1'($urandom_range(0, 1));
      step();
      check("reset_outputs", 32'({x_addr, f_addr, mac_en, mac_clr, m_valid, mem_reload}), 32'd0);
      check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    x_loaded = 1'b0;
    f_loaded = 1'b0;
    m_ready  = 1'b1;
    reset    = 1'b0;
    step();

    // Only x loaded: must stay idle.
    load_vector();
    x_loaded = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("xonly_state", 32'(state_dbg), 32'(ST_IDLE));
      check("xonly_addr", 32'({x_addr, f_addr}), 32'd0);
      check("xonly_mac_en", 32'(mac_en), 32'd0);
    end
    f_loaded = 1'b1;
    step();
    check("start_state", 32'(state_dbg), 32'(ST_COMPUTE));
    for (int o = 0; o < NUM_OUT; o++) run_output(o, 0);
    finish_vector();
    check("reload_count_a", 32'(reload_cnt), 32'd1);

    // Backpressure on the first output of a vector.
    start_vector();
    run_output(0, 3);
    check("after_stall_state", 32'(state_dbg), 32'(ST_COMPUTE));
    for (int o = 1; o < NUM_OUT; o++) run_output(o, 0);
    finish_vector();

    // Reset during output 2, then a full restart from out_idx 0.
    start_vector();
    run_output(0, 0);
    run_output(1, 0);
    check_cycle(2, 0);
    step();
    check_cycle(2, 1);
    step();
    check_cycle(2, 2);
    reset = 1'b1;
    step();
    check("midreset_outputs", 32'({x_addr, f_addr, mac_en, mac_clr, m_valid, mem_reload}), 32'd0);
    check("midreset_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.delete();
    push_expected();
    reset = 1'b0;
    step();
    check("restart_state", 32'(state_dbg), 32'(ST_COMPUTE));
    for (int o = 0; o < NUM_OUT; o++) run_output(o, 0);
    finish_vector();

    // Two vectors back to back through the write-controller model.
    reload_cnt = 0;
    n_outputs  = 0;
    for (int v = 0; v < 2; v++) begin
      start_vector();
      for (int o = 0; o < NUM_OUT; o++) run_output(o, 0);
      finish_vector();
    end
    check("b2b_outputs", 32'(n_outputs), 32'd10);
    check("b2b_reloads", 32'(reload_cnt), 32'd2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
